// File: rtl/carregador_instrucao.sv
// Instruction-memory loader: turns a length-prefixed, XOR-checksummed byte stream into
// big-endian 32-bit words written at sequential addresses from 0.
module carregador_instrucao #(
  parameter int PROFUNDIDADE     = 231,
  parameter int LARGURA_ENDERECO = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        iniciar,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic                        escrita_enable,
  output logic [LARGURA_ENDERECO-1:0] escrita_endereco,
  output logic [31:0]                 escrita_dado,
  output logic                        ocupado,
  output logic                        concluido,
  output logic                        erro,
  output logic [15:0]                 palavras_escritas
);

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] CONT_H    = 3'd1;
  localparam logic [2:0] CONT_L    = 3'd2;
  localparam logic [2:0] DADO      = 3'd3;
  localparam logic [2:0] ESCRITA   = 3'd4;
  localparam logic [2:0] CHECKSUM  = 3'd5;
  localparam logic [2:0] CONCLUIDO = 3'd6;
  localparam logic [2:0] ERRO      = 3'd7;

  localparam logic [LARGURA_ENDERECO-1:0] UM_ENDERECO = {{(LARGURA_ENDERECO-1){1'b0}}, 1'b1};

  logic [2:0]                  estado_q,   estado_d;
  logic [15:0]                 n_q,        n_d;
  logic [15:0]                 palavras_q, palavras_d;
  logic [LARGURA_ENDERECO-1:0] addr_q,     addr_d;
  logic [23:0]                 word_q,     word_d;
  logic [1:0]                  fase_q,     fase_d;
  logic [7:0]                  cksum_q,    cksum_d;
  logic [31:0]                 dado_q,     dado_d;
  logic [LARGURA_ENDERECO-1:0] end_q,      end_d;

  logic        aceita;
  logic [15:0] n_novo;

  assign byte_ready = (estado_q == CONT_H) || (estado_q == CONT_L) ||
                      (estado_q == DADO)   || (estado_q == CHECKSUM);
  assign ocupado           = byte_ready || (estado_q == ESCRITA);
  assign escrita_enable    = (estado_q == ESCRITA);
  assign concluido         = (estado_q == CONCLUIDO);
  assign erro              = (estado_q == ERRO);
  assign escrita_dado      = dado_q;
  assign escrita_endereco  = end_q;
  assign palavras_escritas = palavras_q;
  assign aceita            = byte_valid && byte_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    estado_d   = estado_q;
    n_d        = n_q;
    palavras_d = palavras_q;
    addr_d     = addr_q;
    word_d     = word_q;
    fase_d     = fase_q;
    cksum_d    = cksum_q;
    dado_d     = dado_q;
    end_d      = end_q;
    n_novo     = {n_q[15:8], byte_in};

    case (estado_q)
      OCIOSO, CONCLUIDO, ERRO: begin
        if (iniciar) begin
          estado_d   = CONT_H;
          n_d        = '0;
          palavras_d = '0;
          addr_d     = '0;
          cksum_d    = '0;
          fase_d     = '0;
        end
      end
      CONT_H: begin
        if (aceita) begin
          n_d      = {byte_in, 8'h00};
          estado_d = CONT_L;
        end
      end
      CONT_L: begin
        if (aceita) begin
          n_d = n_novo;
          if (n_novo == 16'd0)                     estado_d = CHECKSUM;
          else if (n_novo > 16'(PROFUNDIDADE))     estado_d = ERRO;
          else                                     estado_d = DADO;
        end
      end
      DADO: begin
        if (aceita) begin
          word_d  = {word_q[15:0], byte_in};
          cksum_d = cksum_q ^ byte_in;
          fase_d  = fase_q + 2'd1;
          // Output registers are loaded here so they hold the word after the strobe.
          if (fase_q == 2'd3) begin
            dado_d   = {word_q, byte_in};
            end_d    = addr_q;
            estado_d = ESCRITA;
          end
        end
      end
      ESCRITA: begin
        addr_d     = addr_q + UM_ENDERECO;
        palavras_d = palavras_q + 16'd1;
        estado_d   = (palavras_q + 16'd1 == n_q) ? CHECKSUM : DADO;
      end
      CHECKSUM: begin
        if (aceita) estado_d = (byte_in == cksum_q) ? CONCLUIDO : ERRO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: every register, data path included, is reset so no stale word or address leaks out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      n_q        <= '0;
      palavras_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      fase_q     <= '0;
      cksum_q    <= '0;
      dado_q     <= '0;
      end_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      estado_q   <= estado_d;
      n_q        <= n_d;
      palavras_q <= palavras_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      fase_q     <= fase_d;
      cksum_q    <= cksum_d;
      dado_q     <= dado_d;
      end_q      <= end_d;
    end
  end

endmodule

// File: tb/tb_carregador_instrucao.sv
// Self-checking bench for carregador_instrucao: session table plus reset-mid-word sequence,
// with a write scoreboard fed as words are streamed and drained on each write strobe.
module tb_carregador_instrucao;

  localparam int PROF = 231;
  localparam int LA   = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          iniciar;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          escrita_enable;
  logic [LA-1:0] escrita_endereco;
  logic [31:0]   escrita_dado;
  logic          ocupado;
  logic          concluido;
  logic          erro;
  logic [15:0]   palavras_escritas;

  carregador_instrucao #(.PROFUNDIDADE(PROF), .LARGURA_ENDERECO(LA)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .iniciar           (iniciar),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .escrita_enable    (escrita_enable),
    .escrita_endereco  (escrita_endereco),
    .escrita_dado      (escrita_dado),
    .ocupado           (ocupado),
    .concluido         (concluido),
    .erro              (erro),
    .palavras_escritas (palavras_escritas)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [31:0] w0;
    logic [7:0]  ck_flip;
    bit          gaps;
    bit          exp_ok;
    int          exp_words;
  } vec_t;

  wr_t  exp_q[$];
  int   strobe_cyc[$];
  wr_t  mon_e;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard drain: every strobe must match the oldest pending word.
  always @(negedge clock) begin
    if (escrita_enable === 1'b1) begin
      strobe_cyc.push_back(cyc);
      check("strobe_ready_low", {63'd0, byte_ready}, 64'd0);
      check("strobe_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {32'd0, escrita_endereco}, {32'd0, mon_e.addr});
        check("wr_data", {32'd0, escrita_dado}, {32'd0, mon_e.data});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left at 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clock);
      ok = byte_ready;
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
    check("byte_accepted", {63'd0, ok}, 64'd1);
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] n16;
    logic [31:0] w;
    logic [7:0]  ck;
    n16 = v.n[15:0];
    ck  = 8'h00;
    strobe_cyc.delete();
    pulse_iniciar();
    check("start_ocupado", {63'd0, ocupado}, 64'd1);
    check("start_flags_clear", {62'd0, concluido, erro}, 64'd0);
    check("start_palavras", {48'd0, palavras_escritas}, 64'd0);
    send_byte(n16[15:8], v.gaps);
    send_byte(n16[7:0], v.gaps);
    if (v.n > PROF) begin
      check("oversize_erro", {63'd0, erro}, 64'd1);
      check("oversize_ready", {63'd0, byte_ready}, 64'd0);
      repeat (3) begin
        @(posedge clock); #1;
      end
      check("oversize_ready_later", {63'd0, byte_ready}, 64'd0);
    end else begin
      for (int i = 0; i < v.n; i++) begin
        w = v.w0 + 32'(i) * 32'h01030507;
        exp_q.push_back('{addr: 32'(i), data: w});
        for (int b = 3; b >= 0; b--) begin
          send_byte(w[8*b +: 8], v.gaps);
          ck = ck ^ w[8*b +: 8];
        end
        if (v.gaps && i == 0) begin
          pulse_iniciar();
          check("busy_iniciar_ignored", {63'd0, ocupado}, 64'd1);
        end
      end
      send_byte(ck ^ v.ck_flip, v.gaps);
    end
    check("end_concluido", {63'd0, concluido}, {63'd0, v.exp_ok});
    check("end_erro", {63'd0, erro}, {63'd0, !v.exp_ok});
    check("end_palavras", {48'd0, palavras_escritas}, 64'(v.exp_words));
    check("end_ocupado", {63'd0, ocupado}, 64'd0);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("strobe_count", 64'(strobe_cyc.size()), 64'(v.exp_words));
    if (idx == 1) begin
      for (int i = 1; i < strobe_cyc.size(); i++)
        check("strobe_spacing", 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd5);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {59'd0, ocupado, byte_ready, escrita_enable, concluido, erro}, 64'd0);
    check({tag, "_palavras"}, {48'd0, palavras_escritas}, 64'd0);
    check({tag, "_addr"}, {32'd0, escrita_endereco}, 64'd0);
    check({tag, "_data"}, {32'd0, escrita_dado}, 64'd0);
  endtask

  initial begin
    //          n    w0            flip   gaps  ok    words
    vecs[0] = '{1,   32'hFC000021, 8'h00, 1'b0, 1'b1, 1};
    vecs[1] = '{3,   32'h12345678, 8'h00, 1'b0, 1'b1, 3};
    vecs[2] = '{0,   32'h00000000, 8'h00, 1'b0, 1'b1, 0};
    vecs[3] = '{0,   32'h00000000, 8'h01, 1'b0, 1'b0, 0};
    vecs[4] = '{232, 32'h00000000, 8'h00, 1'b0, 1'b0, 0};
    vecs[5] = '{2,   32'hDEADBEEF, 8'h5A, 1'b0, 1'b0, 2};
    vecs[6] = '{PROF, 32'h0F1E2D3C, 8'h00, 1'b0, 1'b1, PROF};
    vecs[7] = '{4,   32'h89ABCDEF, 8'h00, 1'b1, 1'b1, 4};

    reset_n    = 1'b0;
    iniciar    = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Reset in the middle of a word: nothing may be written and all outputs drop at once.
    pulse_iniciar();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_q.push_back('{addr: 32'd0, data: 32'hA1B2C3D4});
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("midreset_no_strobe", {63'd0, escrita_enable}, 64'd0);

    run_vec(vecs[7], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
